// File: rtl/rptr_empty_ctrl_if.sv
// Read-side FIFO handshake bundle: pop request, synchronized write pointer in,
// flags/address/Gray pointer out. The rlevel signal exists only when RD_LEVEL_EN is defined.
interface rptr_empty_ctrl_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   wptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
`ifdef RD_LEVEL_EN
  logic [ADDRSIZE:0]   rlevel;

  modport master (output rinc, output wptr,
                  input rempty, input raempty, input raddr, input rptr, input rlevel);
  modport slave  (input rinc, input wptr,
                  output rempty, output raempty, output raddr, output rptr, output rlevel);
`else
  modport master (output rinc, output wptr,
                  input rempty, input raempty, input raddr, input rptr);
  modport slave  (input rinc, input wptr,
                  output rempty, output raempty, output raddr, output rptr);
`endif
endinterface

// File: rtl/rptr_empty_ctrl.sv
// Async FIFO read-side pointer/flag controller: 2-flop wptr sync, Gray/binary read pointer,
// registered empty and almost-empty flags. Define RD_LEVEL_EN to add the registered rlevel output.
module rptr_empty_ctrl #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  rptr_empty_ctrl_if.slave rif
);

  localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE+1)'(AE_THRESH);

  logic [ADDRSIZE:0] rq1_wptr_q, rq1_wptr_d;
  logic [ADDRSIZE:0] rq2_wptr_q, rq2_wptr_d;
  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              rd_pop;
  logic [ADDRSIZE:0] rq2_wbin;
  logic [ADDRSIZE:0] lvl;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
    assign rq2_wbin[gi] = ^rq2_wptr_q[ADDRSIZE:gi];
  end

  always_comb begin
    rq1_wptr_d = rif.wptr;
    rq2_wptr_d = rq1_wptr_q;
    rd_pop     = rif.rinc & ~rempty_q;
    rbin_d     = rbin_q + {{ADDRSIZE{1'b0}}, rd_pop};
    rptr_d     = (rbin_d >> 1) ^ rbin_d;
    // Flags look at the post-pop pointer so the last pop sets empty on the same edge.
    rempty_d   = (rptr_d == rq2_wptr_q);
    lvl        = rq2_wbin - rbin_d;
    raempty_d  = (lvl <= AE_LIMIT);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
    end else begin
      rq1_wptr_q <= rq1_wptr_d;
      rq2_wptr_q <= rq2_wptr_d;
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
    end
  end

  assign rif.rempty  = rempty_q;
  assign rif.raempty = raempty_q;
  assign rif.raddr   = rbin_q[ADDRSIZE-1:0];
  assign rif.rptr    = rptr_q;

`ifdef RD_LEVEL_EN
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;

  always_comb begin
    rlevel_d = lvl;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= rlevel_d;
    end
  end

  assign rif.rlevel = rlevel_q;
`endif

endmodule
